// File: rtl/or_bus_initiator.sv
// rtl/or_bus_initiator.sv - bus initiator running poll/write/read sequences against the 1-bit OR DUT
// Each accepted (a, b) job becomes one complete DUT transaction sequence and ends in one response.
module or_bus_initiator #(
  parameter int POLL_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_a,
  input  logic             job_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_y,
  output logic             res_err,
  output logic [2:0]       write_address,
  output logic             write_data,
  output logic             write_en,
  input  logic             write_rdy,
  output logic [2:0]       read_address,
  output logic             read_en,
  input  logic             read_data,
  input  logic             read_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RESP
  } state_t;

  state_t     state;
  logic       a_q;
  logic       b_q;
  logic [7:0] poll_cnt;

  // Bus outputs decode the registered state so they drop as soon as RST forces IDLE.
  always_comb begin
    read_address  = 3'd0;
    read_en       = 1'b0;
    write_address = 3'd0;
    write_data    = 1'b0;
    write_en      = 1'b0;
    case (state)
      POLL_A: begin read_address = 3'd0; read_en = read_rdy; end
      POLL_B: begin read_address = 3'd1; read_en = read_rdy; end
      POLL_Y: begin read_address = 3'd2; read_en = read_rdy; end
      RD_Y:   begin read_address = 3'd3; read_en = read_rdy; end
      WR_A:   begin write_address = 3'd4; write_data = a_q; write_en = write_rdy; end
      WR_B:   begin write_address = 3'd5; write_data = b_q; write_en = write_rdy; end
      default: ;
    endcase
  end

  assign job_ready = (state == IDLE) && !RST;
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      poll_cnt   <= 8'd0;
      res_y      <= 1'b0;
      res_err    <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: if (job_valid) begin
          a_q      <= job_a;
          b_q      <= job_b;
          poll_cnt <= 8'd0;
          res_y    <= 1'b0;
          res_err  <= 1'b0;
          state    <= POLL_A;
        end
        POLL_A, POLL_B, POLL_Y: if (read_rdy) begin
          if (read_data) begin
            state <= (state == POLL_A) ? WR_A : (state == POLL_B) ? WR_B : RD_Y;
          end else if (poll_cnt == LIMIT - 8'd1) begin
            // Abort; anything already written stays queued in the DUT.
            res_err <= 1'b1;
            res_y   <= 1'b0;
            state   <= RESP;
          end else begin
            poll_cnt <= poll_cnt + 8'd1;
          end
        end
        WR_A: if (write_rdy) begin
          poll_cnt <= 8'd0;
          state    <= POLL_B;
        end
        WR_B: if (write_rdy) begin
          poll_cnt <= 8'd0;
          state    <= POLL_Y;
        end
        RD_Y: if (read_rdy) begin
          res_y   <= read_data;
          res_err <= 1'b0;
          state   <= RESP;
        end
        RESP: if (res_ready) begin
          if (!res_err) done_count <= done_count + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_bus_initiator.sv
// tb/tb_or_bus_initiator.sv - directed and randomized self-checking bench for or_bus_initiator
module tb_or_bus_initiator;
  localparam int PL = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        job_valid = 1'b0, job_a = 1'b0, job_b = 1'b0;
  logic        job_ready, res_valid, res_y, res_err, busy;
  logic        res_ready = 1'b0;
  logic [2:0]  write_address, read_address;
  logic        write_data, write_en, write_rdy, read_en, read_data;
  logic        read_rdy = 1'b1;
  logic [15:0] done_count;

  int checks = 0;
  int failures = 0;
  int exp_done = 0;

  // Behavioural DUT-side model: status registers, a stall counter for WR_B and the OR result.
  logic a_stat = 1'b1, b_stat = 1'b1, y_hold_zero = 1'b0, dut_a = 1'b0, dut_b = 1'b0;
  int   y_zero_left = 0, wb_stall_left = 0, wb_stall_seen = 0, viol = 0;
  bit   rand_mode = 0;
  int   trace[$];

  or_bus_initiator #(.POLL_LIMIT(PL), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_err(res_err),
    .write_address(write_address), .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data), .read_rdy(read_rdy),
    .busy(busy), .done_count(done_count)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    read_data = 1'b0;
    case (read_address)
      3'd0: read_data = a_stat;
      3'd1: read_data = b_stat;
      3'd2: read_data = (y_zero_left == 0) && !y_hold_zero;
      3'd3: read_data = dut_a | dut_b;
      default: read_data = 1'b0;
    endcase
    write_rdy = !(write_address == 3'd5 && wb_stall_left != 0);
  end

  always @(posedge CLK) begin
    if (write_en && !write_rdy) viol++;
    if (read_en && !read_rdy) viol++;
    if (write_en && read_en) viol++;
    if (read_en) begin
      trace.push_back(int'(read_address));
      if (read_address == 3'd2 && y_zero_left > 0) y_zero_left <= y_zero_left - 1;
    end
    if (write_en) begin
      trace.push_back(100 + 10 * int'(write_address) + int'(write_data));
      if (write_address == 3'd4) dut_a <= write_data;
      if (write_address == 3'd5) dut_b <= write_data;
    end
    if (write_address == 3'd5 && !write_en) begin
      wb_stall_seen++;
      if (wb_stall_left > 0) wb_stall_left <= wb_stall_left - 1;
    end
  end

  initial forever begin
    @(negedge CLK);
    read_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_job(input logic a, input logic b, input int yz, input int wbs,
                        input bit abort, input bit chk_lat);
    int lat;
    int exp_q[$];
    int bad;
    logic y_first;
    @(negedge CLK);
    y_zero_left   = yz;
    wb_stall_left = wbs;
    y_hold_zero   = abort;
    chk("job_ready_idle", job_ready, 1);
    trace.delete();
    wb_stall_seen = 0;
    job_valid = 1'b1; job_a = a; job_b = b;
    @(negedge CLK);
    job_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 400) begin
      @(negedge CLK);
      lat++;
    end
    chk("res_valid_seen", res_valid, 1);
    if (chk_lat) chk("latency", lat, abort ? 5 + PL : 7 + yz + wbs);
    chk("res_y", res_y, abort ? 0 : 32'(a | b));
    chk("res_err", res_err, 32'(abort));
    y_first = res_y;
    repeat (2) @(negedge CLK);
    chk("res_valid_held", res_valid, 1);
    chk("res_y_stable", res_y, 32'(y_first));
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    y_hold_zero = 1'b0;
    if (!abort) exp_done = (exp_done + 1) % 65536;
    chk("res_valid_drop", res_valid, 0);
    chk("job_ready_back", job_ready, 1);
    chk("done_count", done_count, 32'(exp_done));
    chk("wb_stall_cycles", wb_stall_seen, wbs);
    exp_q = '{0, 140 + int'(a), 1, 150 + int'(b)};
    for (int i = 0; i < (abort ? PL : yz + 1); i++) exp_q.push_back(2);
    if (!abort) exp_q.push_back(3);
    chk("trace_len", trace.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      if (trace[i] != exp_q[i]) bad++;
    chk("trace_content", bad, 0);
  endtask

  initial begin
    int k;
    #1;
    chk("rst_job_ready", job_ready, 0);
    chk("rst_outputs", {busy, res_valid, read_en, write_en, read_address, write_address,
                        write_data, res_y, res_err}, 0);
    chk("rst_done_count", done_count, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_job_ready", job_ready, 1);

    do_job(1'b1, 1'b0, 0, 0, 0, 1);
    do_job(1'b0, 1'b0, 0, 0, 0, 1);
    do_job(1'b0, 1'b1, 0, 0, 0, 1);
    do_job(1'b1, 1'b1, 0, 0, 0, 1);
    do_job(1'b1, 1'b0, 5, 0, 0, 1);
    do_job(1'b0, 1'b1, PL - 1, 0, 0, 1);
    do_job(1'b1, 1'b1, 0, 0, 1, 1);
    do_job(1'b0, 1'b1, 0, 3, 0, 1);
    do_job(1'b1, 1'b0, 2, 3, 0, 1);

    // Reset while the initiator sits polling B status.
    @(negedge CLK);
    b_stat = 1'b0;
    job_valid = 1'b1; job_a = 1'b1; job_b = 1'b1;
    @(negedge CLK);
    job_valid = 1'b0;
    k = 0;
    while (read_address != 3'd1 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("reached_poll_b", read_address, 1);
    RST = 1'b1;
    #1;
    chk("midrst_outputs", {busy, res_valid, job_ready, read_en, write_en, read_address,
                           write_address, write_data, res_y, res_err}, 0);
    chk("midrst_done_count", done_count, 0);
    @(negedge CLK);
    RST = 1'b0;
    b_stat = 1'b1;
    exp_done = 0;
    #1;
    chk("post_midrst_no_resp", res_valid, 0);
    do_job(1'b0, 1'b1, 0, 0, 0, 1);

    rand_mode = 1;
    for (int i = 0; i < 10; i++)
      do_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             $urandom_range(0, 2), 0, 0);
    rand_mode = 0;

    chk("enable_rule", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
